// File: rtl/tl_periph_pkg.sv
// rtl/tl_periph_pkg.sv - host identifiers shared by the two-host TL-UL arbiter
// Ports: none (package).
package tl_periph_pkg;

    localparam int NumArbHosts = 2;

    typedef enum logic {
        HostIf  = 1'b0,
        HostLsu = 1'b1
    } arb_host_e;

    function automatic arb_host_e other_host(input arb_host_e h);
        return (h == HostIf) ? HostLsu : HostIf;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL host-to-device and device-to-host channel structs
// Ports: none (package).
package tlul_pkg;

    // Request direction: A-channel payload plus the host's D-channel ready.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    // Response direction: D-channel payload plus the device's A-channel ready.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idfifo.sv
// rtl/tlul_arb_idfifo.sv - in-order FIFO of 1-bit host IDs for outstanding A beats
// Ports: clk_i/rst_ni clock and sync active-low reset; push/wdata write side;
//        pop/rdata read side (rdata is the head); full, empty, count status.
module tlul_arb_idfifo #(
    parameter  int Depth = 4,
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  logic            wdata,
    input  logic            pop,
    output logic            rdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/tlul_host_arb.sv
// rtl/tlul_host_arb.sv - zero-latency two-host TL-UL arbiter onto one shared device
// Ports: clk_i/rst_ni clock and sync active-low reset; tl_h0_i/tl_h0_o host 0
//        (instruction fetch); tl_h1_i/tl_h1_o host 1 (LSU); tl_d_o/tl_d_i shared
//        device; err_o sticky flag for a device response with nothing outstanding.
module tlul_host_arb
    import tlul_pkg::*;
    import tl_periph_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  tl_h2d_t  tl_h0_i,
    output tl_d2h_t  tl_h0_o,
    input  tl_h2d_t  tl_h1_i,
    output tl_d2h_t  tl_h1_o,
    output tl_h2d_t  tl_d_o,
    input  tl_d2h_t  tl_d_i,
    output logic     err_o
);

    arb_host_e prio_q;
    arb_host_e lock_host_q;
    logic      lock_q;
    logic      err_q;

    arb_host_e gnt;
    arb_host_e head;
    logic      gnt_req;
    logic      a_go;
    logic      a_hs;
    logic      head_d_ready;
    logic      d_hs;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_rdata;
    logic [$clog2(Depth+1)-1:0] fifo_count;
    logic                       unused_fifo_count;

    // A stalled beat keeps its grant so the host's a_valid stays stable;
    // otherwise a lone requester wins and a tie goes to prio_q.
    always_comb begin
        if (lock_q) begin
            gnt = lock_host_q;
        end else if (tl_h0_i.a_valid && !tl_h1_i.a_valid) begin
            gnt = HostIf;
        end else if (tl_h1_i.a_valid && !tl_h0_i.a_valid) begin
            gnt = HostLsu;
        end else begin
            gnt = prio_q;
        end
    end

    assign gnt_req = (gnt == HostLsu) ? tl_h1_i.a_valid : tl_h0_i.a_valid;
    assign a_go    = gnt_req && !fifo_full && rst_ni;
    assign a_hs    = a_go && tl_d_i.a_ready;

    assign head         = arb_host_e'(fifo_rdata);
    assign head_d_ready = (head == HostLsu) ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    assign d_hs         = rst_ni && !fifo_empty && tl_d_i.d_valid && head_d_ready;

    always_comb begin
        tl_d_o         = (gnt == HostLsu) ? tl_h1_i : tl_h0_i;
        tl_d_o.a_valid = a_go;

        tl_h0_o         = tl_d_i;
        tl_h1_o         = tl_d_i;
        tl_h0_o.a_ready = rst_ni && (gnt == HostIf)  && tl_d_i.a_ready && !fifo_full;
        tl_h1_o.a_ready = rst_ni && (gnt == HostLsu) && tl_d_i.a_ready && !fifo_full;
        tl_h0_o.d_valid = 1'b0;
        tl_h1_o.d_valid = 1'b0;

        // With nothing outstanding (or in reset) a response has no owner, so
        // it is drained here rather than allowed to stall the device.
        if (!rst_ni || fifo_empty) begin
            tl_d_o.d_ready = 1'b1;
        end else begin
            tl_d_o.d_ready = head_d_ready;
            if (head == HostLsu) begin
                tl_h1_o.d_valid = tl_d_i.d_valid;
            end else begin
                tl_h0_o.d_valid = tl_d_i.d_valid;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q      <= HostIf;
            lock_q      <= 1'b0;
            lock_host_q <= HostIf;
            err_q       <= 1'b0;
        end else begin
            if (a_hs) begin
                prio_q <= other_host(gnt);
                lock_q <= 1'b0;
            end else if (gnt_req) begin
                lock_q      <= 1'b1;
                lock_host_q <= gnt;
            end else begin
                lock_q <= 1'b0;
            end
            if (fifo_empty && tl_d_i.d_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

    tlul_arb_idfifo #(
        .Depth (Depth)
    ) u_idfifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (a_hs),
        .wdata  (logic'(gnt)),
        .pop    (d_hs),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

endmodule

// File: tb/tb_tlul_host_arb.sv
// tb/tb_tlul_host_arb.sv - scoreboard bench for the two-host TL-UL arbiter
module tb_tlul_host_arb;
    import tlul_pkg::*;

    logic    clk_i;
    logic    rst_ni;
    tl_h2d_t tl_h0_i;
    tl_d2h_t tl_h0_o;
    tl_h2d_t tl_h1_i;
    tl_d2h_t tl_h1_o;
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;
    logic    err_o;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    tlul_host_arb #(.Depth(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tl_h0_i (tl_h0_i),
        .tl_h0_o (tl_h0_o),
        .tl_h1_i (tl_h1_i),
        .tl_h1_o (tl_h1_o),
        .tl_d_o  (tl_d_o),
        .tl_d_i  (tl_d_i),
        .err_o   (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] src(input int h);
        return (h == 1) ? 8'h20 : 8'h10;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_host(input int h, input logic v, input logic [31:0] addr);
        if (h == 1) begin
            tl_h1_i.a_valid   = v;
            tl_h1_i.a_source  = src(1);
            tl_h1_i.a_address = addr;
            tl_h1_i.a_data    = addr ^ 32'h5a5a_5a5a;
        end else begin
            tl_h0_i.a_valid   = v;
            tl_h0_i.a_source  = src(0);
            tl_h0_i.a_address = addr;
            tl_h0_i.a_data    = addr ^ 32'h5a5a_5a5a;
        end
    endtask

    // One accepted A beat from host h with no competing request.
    task automatic issue(input int h, input logic [31:0] addr);
        set_host(h, 1'b1, addr);
        #1;
        check("issue_a_valid", tl_d_o.a_valid, 1);
        check("issue_a_source", tl_d_o.a_source, src(h));
        check("issue_a_address", tl_d_o.a_address, addr);
        check("issue_a_ready", (h == 1) ? tl_h1_o.a_ready : tl_h0_o.a_ready, 1);
        exp_q.push_back(h);
        tick();
        set_host(h, 1'b0, 32'h0);
    endtask

    // Present a D beat and compare routing against the scoreboard head.
    task automatic d_beat(input logic [31:0] data);
        int h;
        tl_d_i.d_valid = 1'b1;
        tl_d_i.d_data  = data;
        #1;
        if (exp_q.size() == 0) begin
            check("d_scoreboard_empty", 0, 1);
        end else begin
            h = exp_q.pop_front();
            check("d_valid_owner", (h == 1) ? tl_h1_o.d_valid : tl_h0_o.d_valid, 1);
            check("d_valid_other", (h == 1) ? tl_h0_o.d_valid : tl_h1_o.d_valid, 0);
            check("d_data_owner", (h == 1) ? tl_h1_o.d_data : tl_h0_o.d_data, data);
            check("d_ready_dev", tl_d_o.d_ready, 1);
        end
    endtask

    task automatic d_cycle(input logic [31:0] data);
        d_beat(data);
        tick();
        tl_d_i.d_valid = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        tl_h0_i = '0;
        tl_h1_i = '0;
        tl_d_i  = '0;
        tl_h0_i.d_ready = 1'b1;
        tl_h1_i.d_ready = 1'b1;
        tl_d_i.a_ready  = 1'b1;
        tl_d_i.d_opcode = 3'd1;
        repeat (2) tick();

        // Reset: both hosts requesting and a stray D beat must all be masked.
        set_host(0, 1'b1, 32'h0000_0010);
        set_host(1, 1'b1, 32'h0000_0020);
        tl_d_i.d_valid = 1'b1;
        #1;
        check("rst_dev_a_valid", tl_d_o.a_valid, 0);
        check("rst_h0_a_ready", tl_h0_o.a_ready, 0);
        check("rst_h1_a_ready", tl_h1_o.a_ready, 0);
        check("rst_h0_d_valid", tl_h0_o.d_valid, 0);
        check("rst_h1_d_valid", tl_h1_o.d_valid, 0);
        check("rst_dev_d_ready", tl_d_o.d_ready, 1);
        check("rst_err", err_o, 0);
        check("rst_count", dut.fifo_count, 0);
        tick();
        check("rst_err_hold", err_o, 0);
        tl_d_i.d_valid = 1'b0;

        // Both request right after reset: host 0 first, then host 1.
        rst_ni = 1'b1;
        #1;
        check("rr_first_src", tl_d_o.a_source, src(0));
        check("rr_first_h0_ready", tl_h0_o.a_ready, 1);
        check("rr_first_h1_ready", tl_h1_o.a_ready, 0);
        exp_q.push_back(0);
        tick();
        set_host(0, 1'b0, 32'h0);
        #1;
        check("rr_second_src", tl_d_o.a_source, src(1));
        check("rr_second_h1_ready", tl_h1_o.a_ready, 1);
        check("rr_second_h0_ready", tl_h0_o.a_ready, 0);
        exp_q.push_back(1);
        tick();
        set_host(1, 1'b0, 32'h0);
        set_host(0, 1'b1, 32'h0000_0030);
        set_host(1, 1'b1, 32'h0000_0040);
        #1;
        check("rr_prio_back_h0", tl_d_o.a_source, src(0));
        set_host(0, 1'b0, 32'h0);
        set_host(1, 1'b0, 32'h0);
        #1;
        d_cycle(32'h0000_00B0);
        d_cycle(32'h0000_00B1);

        // Lock: host 0 stalls while prio points at host 1.
        issue(0, 32'h0000_0100);
        d_cycle(32'h0000_00B2);
        tl_d_i.a_ready = 1'b0;
        set_host(0, 1'b1, 32'h0000_0200);
        #1;
        check("lock_first_src", tl_d_o.a_source, src(0));
        check("lock_first_h0_ready", tl_h0_o.a_ready, 0);
        tick();
        set_host(1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_hold_src", tl_d_o.a_source, src(0));
            check("lock_hold_addr", tl_d_o.a_address, 32'h0000_0200);
            check("lock_hold_valid", tl_d_o.a_valid, 1);
            check("lock_hold_h1_ready", tl_h1_o.a_ready, 0);
            tick();
        end
        tl_d_i.a_ready = 1'b1;
        #1;
        check("lock_release_h0_ready", tl_h0_o.a_ready, 1);
        check("lock_release_src", tl_d_o.a_source, src(0));
        exp_q.push_back(0);
        tick();
        set_host(0, 1'b0, 32'h0);
        #1;
        check("lock_next_h1_ready", tl_h1_o.a_ready, 1);
        check("lock_next_addr", tl_d_o.a_address, 32'h0000_0300);
        exp_q.push_back(1);
        tick();
        set_host(1, 1'b0, 32'h0);
        d_cycle(32'h0000_00B3);
        d_cycle(32'h0000_00B4);

        // Full: four outstanding, the fifth waits for a pop without bypass.
        for (int i = 0; i < 4; i++) issue(0, 32'h0000_0400 + 32'(i * 4));
        check("full_count", dut.fifo_count, 4);
        set_host(0, 1'b1, 32'h0000_0410);
        #1;
        check("full_h0_ready", tl_h0_o.a_ready, 0);
        check("full_dev_a_valid", tl_d_o.a_valid, 0);
        tick();
        d_beat(32'h0000_00C0);
        check("full_no_bypass", tl_h0_o.a_ready, 0);
        tick();
        tl_d_i.d_valid = 1'b0;
        #1;
        check("full_fifth_ready", tl_h0_o.a_ready, 1);
        check("full_fifth_valid", tl_d_o.a_valid, 1);
        check("full_fifth_addr", tl_d_o.a_address, 32'h0000_0410);
        exp_q.push_back(0);
        tick();
        set_host(0, 1'b0, 32'h0);
        for (int i = 1; i < 5; i++) d_cycle(32'h0000_00C0 + 32'(i));

        // Interleave 0,1,1,0 with one push and pop in the same cycle.
        issue(0, 32'h0000_0500);
        issue(1, 32'h0000_0504);
        set_host(1, 1'b1, 32'h0000_0508);
        d_beat(32'h0000_00A0);
        check("pp_h1_ready", tl_h1_o.a_ready, 1);
        exp_q.push_back(1);
        tick();
        tl_d_i.d_valid = 1'b0;
        set_host(1, 1'b0, 32'h0);
        check("pp_count", dut.fifo_count, 2);
        issue(0, 32'h0000_050C);
        d_cycle(32'h0000_00A1);
        d_cycle(32'h0000_00A2);
        d_cycle(32'h0000_00A3);
        check("drained_count", dut.fifo_count, 0);

        // Orphan response: drained, unrouted, sticky error.
        tl_h0_i.d_ready = 1'b0;
        tl_h1_i.d_ready = 1'b0;
        tl_d_i.d_valid  = 1'b1;
        tl_d_i.d_data   = 32'h0000_00EE;
        #1;
        check("orphan_h0_d_valid", tl_h0_o.d_valid, 0);
        check("orphan_h1_d_valid", tl_h1_o.d_valid, 0);
        check("orphan_d_ready", tl_d_o.d_ready, 1);
        check("orphan_err_before", err_o, 0);
        tick();
        tl_d_i.d_valid  = 1'b0;
        tl_h0_i.d_ready = 1'b1;
        tl_h1_i.d_ready = 1'b1;
        #1;
        check("orphan_err_set", err_o, 1);
        repeat (3) tick();
        check("orphan_err_sticky", err_o, 1);

        // Reset with two outstanding, then a late response.
        issue(0, 32'h0000_0600);
        issue(1, 32'h0000_0604);
        check("midrst_count_before", dut.fifo_count, 2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_count", dut.fifo_count, 0);
        check("midrst_err", err_o, 0);
        tl_d_i.d_valid = 1'b1;
        #1;
        check("late_h0_d_valid", tl_h0_o.d_valid, 0);
        check("late_h1_d_valid", tl_h1_o.d_valid, 0);
        tick();
        tl_d_i.d_valid = 1'b0;
        #1;
        check("late_err", err_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
